// File: rtl/pnm_fp_pkg.sv
// Shared definitions for the PNM floating-point reduction blocks:
// IEEE-754 single-precision field widths and the reduction FSM states.
package pnm_fp_pkg;

    localparam int FP_W   = 32;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = {EXP_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage : pnm_fp_pkg

// File: rtl/fp_lt.sv
// Sign-magnitude "less than" for IEEE-754 single-precision bit patterns.
// NaN is not special-cased here; callers screen NaNs themselves.
// -0.0 orders strictly below +0.0 because the signs differ.
module fp_lt
    import pnm_fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            lt
);

    logic a_neg;
    logic b_neg;

    assign a_neg = a[FP_W-1];
    assign b_neg = b[FP_W-1];

    // Order by sign first, then by magnitude (reversed for negatives).
    always_comb begin
        lt = 1'b0;
        if (a_neg != b_neg) begin
            lt = a_neg;
        end else if (!a_neg) begin
            lt = (a[FP_W-2:0] < b[FP_W-2:0]);
        end else begin
            lt = (a[FP_W-2:0] > b[FP_W-2:0]);
        end
    end

endmodule : fp_lt

// File: rtl/fp_min_reduce.sv
// Streaming argmin over a vector of IEEE-754 singles.
// Elements arrive on a valid/ready stream terminated by s_last; the minimum,
// its first index, the saturating element count and NaN/overflow flags are
// presented on a registered output that is held until m_ready.
module fp_min_reduce
    import pnm_fp_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FP_W-1:0]   s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FP_W-1:0]   m_min,
    output logic [IDX_W-1:0]  m_idx,
    output logic [IDX_W-1:0]  m_count,
    output logic              m_nan,
    output logic              m_ovf
);

    localparam logic [IDX_W-1:0] CNT_MAX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] CNT_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    // FSM state and running reduction of the vector in flight.
    state_e            state_q, state_d;
    logic [FP_W-1:0]   cur_q,   cur_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [IDX_W-1:0]  cnt_q,   cnt_d;
    logic              nan_q,   nan_d;
    logic              ovf_q,   ovf_d;

    // Registered result presented downstream.
    logic [FP_W-1:0]   m_min_q;
    logic [IDX_W-1:0]  m_idx_q;
    logic [IDX_W-1:0]  m_count_q;
    logic              m_nan_q;
    logic              m_ovf_q;
    logic              load_out;

    logic              xfer;
    logic              in_nan;
    logic              cur_nan;
    logic              in_lt;
    logic              take;

    assign s_ready = (state_q != HOLD);
    assign m_valid = (state_q == HOLD);
    assign xfer    = s_valid & s_ready;

    assign in_nan  = (s_data[FP_W-2 -: EXP_W] == EXP_ALL_ONES) && (s_data[FRAC_W-1:0] != '0);
    assign cur_nan = (cur_q[FP_W-2 -: EXP_W]  == EXP_ALL_ONES) && (cur_q[FRAC_W-1:0]  != '0);

    fp_lt u_fp_lt (
        .a  (s_data),
        .b  (cur_q),
        .lt (in_lt)
    );

    // A NaN never wins; a non-NaN wins over a NaN current minimum or on strict lt.
    assign take = !in_nan && (cur_nan || in_lt);

    // Next-state logic and working-register update for each accepted element.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cur_d    = cur_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        nan_d    = nan_q;
        ovf_d    = ovf_q;
        load_out = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    cur_d = s_data;
                    idx_d = '0;
                    cnt_d = CNT_ONE;
                    nan_d = in_nan;
                    ovf_d = 1'b0;
                    if (s_last) begin
                        state_d  = HOLD;
                        load_out = 1'b1;
                    end else begin
                        state_d  = ACCUM;
                    end
                end
            end

            ACCUM: begin
                if (xfer) begin
                    if (take) begin
                        cur_d = s_data;
                        idx_d = cnt_q;
                    end
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    nan_d = nan_q | in_nan;
                    if (s_last) begin
                        state_d  = HOLD;
                        load_out = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and working registers; reset discards any partial vector.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            nan_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            nan_q   <= nan_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result registers capture the final reduction only on the HOLD entry edge.
    always_ff @(posedge clk) begin
        // NOTE: result registers are reset too, so the output port reads zero rather than stale data after reset.
        if (!rst_n) begin
            m_min_q   <= '0;
            m_idx_q   <= '0;
            m_count_q <= '0;
            m_nan_q   <= 1'b0;
            m_ovf_q   <= 1'b0;
        end else if (load_out) begin
            m_min_q   <= cur_d;
            m_idx_q   <= idx_d;
            m_count_q <= cnt_d;
            m_nan_q   <= nan_d;
            m_ovf_q   <= ovf_d;
        end
    end

    assign m_min   = m_min_q;
    assign m_idx   = m_idx_q;
    assign m_count = m_count_q;
    assign m_nan   = m_nan_q;
    assign m_ovf   = m_ovf_q;

endmodule : fp_min_reduce

// File: tb/tb_fp_min_reduce.sv
// Scoreboard bench for fp_min_reduce. Two instances (IDX_W=16 and IDX_W=2)
// share one input stream; a reference model computes the expected result of
// each vector for both widths and a monitor checks every output handshake.
module tb_fp_min_reduce;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_ready;

    logic        s_ready,  s_ready2;
    logic        m_valid,  m_valid2;
    logic [31:0] m_min,    m_min2;
    logic [15:0] m_idx,    m_count;
    logic [1:0]  m_idx2,   m_count2;
    logic        m_nan,    m_nan2;
    logic        m_ovf,    m_ovf2;

    int n_checks = 0;
    int n_pass   = 0;
    bit mr_auto  = 1'b0;

    typedef struct {
        logic [31:0] min;
        logic [15:0] idx;
        logic [15:0] cnt;
        logic        nan;
        logic        ovf;
        logic [1:0]  idx2;
        logic [1:0]  cnt2;
        logic        ovf2;
    } exp_t;

    exp_t sb[$];

    fp_min_reduce #(.IDX_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_min   (m_min),
        .m_idx   (m_idx),
        .m_count (m_count),
        .m_nan   (m_nan),
        .m_ovf   (m_ovf)
    );

    fp_min_reduce #(.IDX_W(2)) dut_small (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready2),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid2),
        .m_ready (m_ready),
        .m_min   (m_min2),
        .m_idx   (m_idx2),
        .m_count (m_count2),
        .m_nan   (m_nan2),
        .m_ovf   (m_ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps a float to an unsigned key whose integer order is the float order
    // (with -0 below +0).
    function automatic logic [31:0] order_key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic exp_t model(input logic [31:0] v[$]);
        exp_t e;
        int   n = v.size();
        int   best = -1;
        bit   any_nan = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (is_nan(v[i])) any_nan = 1'b1;
            else if (best < 0 || order_key(v[i]) < order_key(v[best])) best = i;
        end
        if (best < 0) best = 0;
        e.min  = v[best];
        e.nan  = any_nan;
        e.idx  = 16'((best > 65535) ? 65535 : best);
        e.cnt  = 16'((n > 65535) ? 65535 : n);
        e.ovf  = (n > 65535);
        e.idx2 = 2'((best > 3) ? 3 : best);
        e.cnt2 = 2'((n > 3) ? 3 : n);
        e.ovf2 = (n > 3);
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] d, input bit last);
        int t = 0;
        while (!s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            fail("s_ready timeout");
            return;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (last) begin
            check("m_valid one cycle after last", {63'd0, m_valid}, 64'd1);
            check("s_ready low in HOLD", {63'd0, s_ready}, 64'd0);
            check("small s_ready low in HOLD", {63'd0, s_ready2}, 64'd0);
        end
    endtask

    task automatic run_vec(input logic [31:0] v[$], input int max_gap);
        sb.push_back(model(v));
        for (int i = 0; i < v.size(); i++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) @(negedge clk);
            send(v[i], (i == v.size() - 1));
        end
    endtask

    function automatic logic [31:0] rand_elem(input logic [31:0] prev);
        logic [31:0] r;
        logic [22:0] frac;
        int          sel = int'($urandom_range(0, 11));
        r    = $urandom();
        frac = 23'($urandom_range(1, 32'h7F_FFFF));
        case (sel)
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7F80_0000;
            3:       return 32'hFF80_0000;
            4:       return {r[31], 8'hFF, frac};
            5:       return prev;
            6:       return {r[31], 8'h7F, r[22:0]};
            default: return r;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " m_valid"},  {63'd0, m_valid}, 64'd0);
        check({tag, " s_ready"},  {63'd0, s_ready}, 64'd1);
        check({tag, " m_min"},    {32'd0, m_min},   64'd0);
        check({tag, " m_idx"},    {48'd0, m_idx},   64'd0);
        check({tag, " m_count"},  {48'd0, m_count}, 64'd0);
        check({tag, " m_nan"},    {63'd0, m_nan},   64'd0);
        check({tag, " m_ovf"},    {63'd0, m_ovf},   64'd0);
        check({tag, " small m_count"}, {62'd0, m_count2}, 64'd0);
    endtask

    // ---------------- random downstream back-pressure ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mr_auto) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    fail("result with no expected vector");
                end else begin
                    e = sb.pop_front();
                    check("m_min",         {32'd0, m_min},    {32'd0, e.min});
                    check("m_idx",         {48'd0, m_idx},    {48'd0, e.idx});
                    check("m_count",       {48'd0, m_count},  {48'd0, e.cnt});
                    check("m_nan",         {63'd0, m_nan},    {63'd0, e.nan});
                    check("m_ovf",         {63'd0, m_ovf},    {63'd0, e.ovf});
                    check("small m_valid", {63'd0, m_valid2}, 64'd1);
                    check("small m_min",   {32'd0, m_min2},   {32'd0, e.min});
                    check("small m_idx",   {62'd0, m_idx2},   {62'd0, e.idx2});
                    check("small m_count", {62'd0, m_count2}, {62'd0, e.cnt2});
                    check("small m_nan",   {63'd0, m_nan2},   {63'd0, e.nan});
                    check("small m_ovf",   {63'd0, m_ovf2},   {63'd0, e.ovf2});
                end
            end
        end
    end

    // ---------------- global watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] v[$];
        logic [31:0] prev;
        int          t;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n   = 1'b1;
        @(negedge clk);
        mr_auto = 1'b1;

        // 1: basic minimum in the middle
        v = '{32'h4040_0000, 32'hBFC0_0000, 32'h4000_0000};
        run_vec(v, 0);

        // 2: -0 below +0, earliest tie kept
        v = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
        run_vec(v, 0);

        // 3: single +inf element, then a long hold with ignored input pulses
        t = 0;
        while (!s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        mr_auto = 1'b0;
        m_ready = 1'b0;
        v = '{32'h7F80_0000};
        run_vec(v, 0);
        for (int k = 0; k < 5; k++) begin
            s_valid = (k % 2 == 0);
            s_data  = $urandom();
            s_last  = 1'b1;
            @(negedge clk);
            check("hold m_valid", {63'd0, m_valid}, 64'd1);
            check("hold s_ready", {63'd0, s_ready}, 64'd0);
            check("hold m_min",   {32'd0, m_min},   64'h7F80_0000);
            check("hold m_idx",   {48'd0, m_idx},   64'd0);
            check("hold m_count", {48'd0, m_count}, 64'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("release m_valid", {63'd0, m_valid}, 64'd0);
        check("release s_ready", {63'd0, s_ready}, 64'd1);
        mr_auto = 1'b1;

        // 4: NaN first element replaced by first non-NaN
        v = '{32'h7FC0_0000, 32'h3F80_0000, 32'h3F00_0000};
        run_vec(v, 0);

        // 5: reset in the middle of a vector discards it
        send(32'h4080_0000, 1'b0);
        send(32'hC000_0000, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("mid-vector reset");
        v = '{32'h4120_0000};
        run_vec(v, 0);

        // 6: descending vector overflows the 2-bit instance
        v = '{32'h40A0_0000, 32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        run_vec(v, 0);

        // randomized vectors
        for (int n = 0; n < 60; n++) begin
            int len = int'($urandom_range(1, 8));
            v = {};
            prev = $urandom();
            for (int i = 0; i < len; i++) begin
                prev = rand_elem(prev);
                v.push_back(prev);
            end
            run_vec(v, 2);
        end

        // drain outstanding results
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) fail("results not drained");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fp_min_reduce
